reduction_lut_sequencer: RTL and testbench



---
 rtl/reduction_pkg.sv | 13 +
 rtl/reduction_rom_bank.sv | 45 ++++
 rtl/reduction_lut_sequencer.sv | 120 ++++++++++++
 tb/tb_reduction_lut_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reduction_pkg.sv
// Shared types and helpers for the reduction LUT sequencer and its ROM bank.
package reduction_pkg;

  localparam int QUINT_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Width needed to hold low word plus one ROM value per quint without wrap.
  function automatic int acc_width(input int mw, input int nq);
    return mw + $clog2(nq + 1);
  endfunction

endpackage

// File: rtl/reduction_rom_bank.sv
// Position-indexed ROM: entry {p, q} = (q << (BASE_POS + 5p)) mod MODULUS_DEF.
// Contents are elaboration-time constants; output is registered (1-cycle latency).
module reduction_rom_bank import reduction_pkg::*; #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int NUM_QUINTS = 8,
  parameter int BASE_POS = 1024,
  parameter logic [MODULUS_WIDTH-1:0] MODULUS_DEF = {1'b1, {(MODULUS_WIDTH-2){1'b0}}, 1'b1},
  parameter int ADDR_W = 8
)(
  input  logic                     clk,
  input  logic [ADDR_W-1:0]        addr,
  output logic [MODULUS_WIDTH-1:0] data
);

  localparam int DEPTH = NUM_QUINTS * (1 << QUINT_W);
  localparam int VW = MODULUS_WIDTH + QUINT_W + 1;

  // Modular doubling keeps every intermediate below 2*M, so huge shifts never
  // need wide arithmetic; loops are chunked to keep constant evaluation short.
  function automatic logic [MODULUS_WIDTH-1:0] rom_entry(input int q, input int e);
    logic [VW-1:0] v, m;
    m = VW'(MODULUS_DEF);
    v = VW'(q);
    for (int k = 0; k < (1 << QUINT_W); k++)
      if (v >= m) v = v - m;
    for (int i = 0; i <= e / 32; i++)
      for (int j = 0; j < 32; j++)
        if (i * 32 + j < e) begin
          v = v << 1;
          if (v >= m) v = v - m;
        end
    return v[MODULUS_WIDTH-1:0];
  endfunction

  logic [MODULUS_WIDTH-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    localparam logic [MODULUS_WIDTH-1:0] ENT =
      rom_entry(g % (1 << QUINT_W), BASE_POS + QUINT_W * (g / (1 << QUINT_W)));
    assign rom[g] = ENT;
  end

  always_ff @(posedge clk) data <= rom[addr];

endmodule

// File: rtl/reduction_lut_sequencer.sv
// Steps through the high quints one per cycle, summing ROM lookups onto low_in.
// Optional REDUCTION_SKIP_ZERO_EN: zero quints are skipped without a ROM issue.
module reduction_lut_sequencer import reduction_pkg::*; #(
  parameter int MODULUS_WIDTH = 1024,
  parameter int NUM_QUINTS = 8,
  parameter int BASE_POS = 1024,
  parameter logic [MODULUS_WIDTH-1:0] MODULUS_DEF = {1'b1, {(MODULUS_WIDTH-2){1'b0}}, 1'b1},
  localparam int ACC_WIDTH = acc_width(MODULUS_WIDTH, NUM_QUINTS)
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [QUINT_W*NUM_QUINTS-1:0] high_in,
  input  logic [MODULUS_WIDTH-1:0]      low_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          acc_out,
  output logic                          busy
);

  localparam int PW = (NUM_QUINTS > 1) ? $clog2(NUM_QUINTS) : 1;
  localparam int SW = QUINT_W * NUM_QUINTS;

  state_t                   state;
  logic [SW-1:0]            sr, sr_next;
  logic [PW-1:0]            pos, pos_issue, pos_next, skip;
  logic [QUINT_W-1:0]       quint;
  logic [ACC_WIDTH-1:0]     acc, ret_add;
  logic [MODULUS_WIDTH-1:0] rom_data;
  logic                     hit, issue, last, ret_vld;

  // sr always holds the unissued quints with quint[pos] at the bottom.
  always_comb begin
    hit  = 1'b0;
    skip = '0;
`ifdef REDUCTION_SKIP_ZERO_EN
    for (int i = NUM_QUINTS - 1; i >= 0; i--)
      if (sr[QUINT_W*i +: QUINT_W] != '0) begin
        hit  = 1'b1;
        skip = PW'(i);
      end
`else
    hit = 1'b1;
`endif
    issue     = (state == RUN) && hit;
    pos_issue = pos + skip;
    pos_next  = pos_issue + PW'(1);
    quint     = sr[QUINT_W*skip +: QUINT_W];
    sr_next   = sr >> (QUINT_W * (int'(skip) + 1));
`ifdef REDUCTION_SKIP_ZERO_EN
    last = (sr_next == '0);
`else
    last = (pos == PW'(NUM_QUINTS - 1));
`endif
    ret_add = ret_vld ? ACC_WIDTH'(rom_data) : '0;
  end

  reduction_rom_bank #(
    .MODULUS_WIDTH(MODULUS_WIDTH),
    .NUM_QUINTS(NUM_QUINTS),
    .BASE_POS(BASE_POS),
    .MODULUS_DEF(MODULUS_DEF),
    .ADDR_W(PW + QUINT_W)
  ) u_rom (
    .clk(clk),
    .addr({pos_issue, quint}),
    .data(rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      pos       <= '0;
      acc       <= '0;
      ret_vld   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ret_vld <= issue;
      case (state)
        IDLE: if (in_valid) begin
          sr       <= high_in;
          acc      <= ACC_WIDTH'(low_in);
          pos      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
`ifdef REDUCTION_SKIP_ZERO_EN
          state    <= (high_in == '0) ? FLUSH : RUN;
`else
          state    <= RUN;
`endif
        end
        RUN: begin
          acc <= acc + ret_add;
          sr  <= sr_next;
          pos <= pos_next;
          if (last) state <= FLUSH;
        end
        FLUSH: begin
          acc       <= acc + ret_add;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_reduction_lut_sequencer.sv
// Directed bench for reduction_lut_sequencer (M=1009, W=10, 2 quints, base 10).
module tb_reduction_lut_sequencer;

  localparam int MW   = 10;
  localparam int NQ   = 2;
  localparam int BASE = 10;
  localparam int MOD  = 1009;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [9:0]    high_in = '0;
  logic [MW-1:0] low_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] acc_out;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint q_acc[$];
  int     q_hs[$];
  int     q_lat[$];
  logic   prev_ov = 1'b0;

  reduction_lut_sequencer #(
    .MODULUS_WIDTH(MW),
    .NUM_QUINTS(NQ),
    .BASE_POS(BASE),
    .MODULUS_DEF(10'd1009)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .high_in(high_in),
    .low_in(low_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: low word plus each quint weighted by its true bit position, mod M.
  function automatic longint model_acc(input logic [9:0] h, input logic [MW-1:0] l);
    longint s;
    s = longint'(l);
    for (int p = 0; p < NQ; p++)
      s += (longint'(h[5*p +: 5]) << (BASE + 5*p)) % MOD;
    return s;
  endfunction

  function automatic int model_lat(input logic [9:0] h);
`ifdef REDUCTION_SKIP_ZERO_EN
    int n;
    n = 0;
    for (int p = 0; p < NQ; p++)
      if (h[5*p +: 5] != 0) n++;
    return n + 2;
`else
    return (h == h) ? NQ + 2 : 0;
`endif
  endfunction

  // Compare process: every cycle, against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      q_acc.delete();
      q_hs.delete();
      q_lat.delete();
      prev_ov = 1'b0;
    end else begin
      chk("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) begin
        if (q_acc.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("acc_out", acc_out, q_acc[0]);
          if (!prev_ov) chk("latency", cyc - q_hs[0], q_lat[0]);
          if (out_ready) begin
            void'(q_acc.pop_front());
            void'(q_hs.pop_front());
            void'(q_lat.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        q_acc.push_back(model_acc(high_in, low_in));
        q_hs.push_back(cyc);
        q_lat.push_back(model_lat(high_in));
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] h, input logic [MW-1:0] l, output int hs);
    in_valid = 1'b1;
    high_in  = h;
    low_in   = l;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        hs = cyc;
        break;
      end
      step();
    end
    if (hs < 0) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input longint lit);
    int found;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        found = 1;
        break;
      end
      step();
    end
    if (found == 0) chk({name, "_timeout"}, 0, 1);
    else chk(name, acc_out, lit);
  endtask

  initial begin
    int hs;
    int hsv[3];
    int sp;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc_out", acc_out, 0);

    send(10'b00001_00001, 10'd0, hs);
    wait_out("ones", 495);
    step();

    send(10'b11111_11111, 10'd1008, hs);
    wait_out("max", 2227);
    step();

    // Backpressure: result must hold while a competing operand is offered.
    out_ready = 1'b0;
    send(10'b00010_00011, 10'd100, hs);
    wait_out("stall_first", 1105);
    in_valid = 1'b1;
    high_in  = 10'b11111_11111;
    low_in   = 10'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_acc", acc_out, 1105);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("release_in_ready", in_ready, 1);

    // Reset while the second quint is being issued.
    send(10'b11111_11111, 10'd9, hs);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    send(10'b00001_00000, 10'd7, hs);
    wait_out("after_reset", 487);
    step();

    send(10'b00000_00000, 10'd5, hs);
    wait_out("zero_high", 5);
    step();
    send(10'b00001_00000, 10'd0, hs);
    wait_out("upper_only", 480);
    step();

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin high_in = 10'b11111_11111; low_in = 10'd1008; end
        1: begin high_in = 10'b00001_00001; low_in = 10'd0;    end
        default: begin high_in = 10'b00011_00010; low_in = 10'd1; end
      endcase
      hsv[k] = -1;
      for (int i = 0; i < 50; i++) begin
        if (in_ready) begin
          hsv[k] = cyc;
          break;
        end
        step();
      end
      if (hsv[k] < 0) chk("b2b_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      sp = hsv[k] - hsv[k-1];
      chk("b2b_spacing", sp, NQ + 3);
    end
    chk("model_pin_462", model_acc(10'b00011_00010, 10'd1), 462);

    for (int i = 0; i < 100; i++) begin
      if (q_acc.size() == 0) break;
      step();
    end
    chk("drain", q_acc.size(), 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
